decode_sequencer: RTL
=====================

Name: decode_sequencer

Overview:
- Top-level phase sequencer and SRAM port owner for the image decompressor.
- Steps the decode through three phases: UART image load, milestone-2 (IDCT/dequantise), then milestone-1 (upsample + colourspace conversion).
- Muxes the single external SRAM port to whichever client owns the current phase, and issues one-cycle start pulses to each milestone.
- Collects the done indications and runs a per-phase watchdog that aborts hung phases.

Parameters:
- TIMEOUT_CYCLES, 24'd4000000, max cycles any single phase may run before error abort.
- CNT_W, 24, watchdog counter width.

Ports:
- Clock  in  1  system clock
- resetn  in  1  async active-low reset
- go  in  1  one-cycle request to begin a decode; also clears error state
- uart_done  in  1  level, UART loader has finished writing SRAM
- m2_done  in  1  level or pulse from milestone 2
- m1_done  in  1  level or pulse from milestone 1 (its m1end)
- uart_addr / uart_wdata / uart_we_n  in  18/16/1  UART client SRAM request
- m2_addr / m2_wdata / m2_we_n  in  18/16/1  milestone-2 SRAM request
- m1_addr / m1_wdata / m1_we_n  in  18/16/1  milestone-1 SRAM request
- SRAM_address  out  18  to SRAM controller
- SRAM_write_data  out  16  to SRAM controller
- SRAM_we_n  out  1  to SRAM controller, active low
- uart_en  out  1  level, UART loader enabled
- m2start  out  1  one-cycle start pulse
- m1start  out  1  one-cycle start pulse
- owner  out  2  0=none, 1=UART, 2=M2, 3=M1
- busy  out  1  high in every state except S_IDLE, S_DONE, S_ERR
- done  out  1  level, decode complete
- error  out  1  level, watchdog fired
- err_phase  out  2  owner code of the phase that timed out

Behaviour:
- Reset (resetn low, async): state S_IDLE, owner=0, uart_en=0, m2start=0, m1start=0, done=0, error=0, err_phase=0, watchdog=0.
- SRAM outputs are a combinational mux on the registered owner. When owner=0: SRAM_address=0, SRAM_write_data=0, SRAM_we_n=1.
- States and transitions:
  - S_IDLE: on go -> S_UART.
  - S_UART: owner=1, uart_en=1. On uart_done -> S_M2_START.
  - S_M2_START: owner=0, m2start=1 for exactly this cycle -> S_M2_RUN.
  - S_M2_RUN: owner=2. On m2_done -> S_M1_START.
  - S_M1_START: owner=0, m1start=1 for exactly this cycle -> S_M1_RUN.
  - S_M1_RUN: owner=3. On m1_done -> S_DONE.
  - S_DONE: done=1, owner=0. On go -> clear done, -> S_UART.
  - S_ERR: error=1, owner=0 (we_n forced 1). On go -> clear error and err_phase, -> S_IDLE. There is no direct restart from S_ERR.
- Handover:
  - Every ownership change passes through one owner=0 cycle, so no client write spans a handover.
  - The milestone sees its start pulse in the same cycle its owner code is still 0. It owns the port from the next cycle.
- Done sampling:
  - Done inputs are honoured only in their own RUN/UART state. Asserted elsewhere, they are ignored.
  - A done level still high from a previous run is not honoured in the START cycle. It is honoured on the first RUN cycle, so clients must drop done on start. Milestone 1 clears m1end on m1start.
- go while busy is ignored. go in the same cycle a phase completes is ignored.
- Watchdog:
  - Cleared to 0 on entry to S_UART, S_M2_RUN and S_M1_RUN; increments each cycle in those states.
  - When watchdog == TIMEOUT_CYCLES-1 and the phase's done is low: -> S_ERR, err_phase=current owner.
  - done and timeout in the same cycle: done wins.
  - The counter saturates; it never wraps.
- Reset mid-operation: everything returns to reset values immediately. Client blocks are reset by the same resetn.
- Latency:
  - go -> owner=1 in 1 cycle.
  - uart_done -> m2start high in the next cycle.
  - m2_done -> m1start 1 cycle later.
  - m1_done -> done 1 cycle later.

Test Plan:
- Reset then idle: SRAM_we_n=1, SRAM_address=0, owner=0, busy=0 for 20 cycles with client we_n driven 0 -> no write reaches the SRAM port.
- Full run: go; uart_done at cycle 50; m2_done pulse 30 cycles after m2start; m1_done 40 cycles after m1start.
  - Required response: owner sequence 1,0,2,0,3,0; exactly one m2start and one m1start pulse; done=1 one cycle after m1_done.
- Mux check: in S_M2_RUN drive m2_addr=18'h3A5F0, m2_wdata=16'hBEEF, m2_we_n=0, with different values on the other clients -> SRAM outputs equal the M2 values.
- Stale done: hold m1_done=1 continuously from before go -> no early completion in S_UART or S_M2_RUN; completion occurs on the first S_M1_RUN cycle.
- Watchdog with TIMEOUT_CYCLES=100: never assert m2_done -> error=1 and err_phase=2 exactly 100 cycles after S_M2_RUN entry; SRAM_we_n=1; then go -> error=0, S_IDLE.
- Ignore rules and reset:
  - go asserted during S_M1_RUN -> no effect.
  - resetn low at S_M2_RUN cycle 10 -> all outputs at reset values in the same cycle.
  - go after release -> clean run.

Source files
------------

// File: rtl/decode_sequencer.sv
// decode_sequencer: steps the decode through UART load, milestone 2 and milestone 1, owns the SRAM port, watchdogs each phase
//   Clock, resetn                    : system clock, async active-low reset
//   go                               : one-cycle decode request, also clears error
//   uart_done, m2_done, m1_done      : phase completion indications
//   uart_*, m2_*, m1_*               : client SRAM requests (addr 18, wdata 16, we_n)
//   SRAM_address/write_data/we_n     : muxed SRAM port, we_n active low
//   uart_en, m2start, m1start        : UART enable level, milestone start pulses
//   owner, busy, done, error, err_phase : status (owner 0=none 1=UART 2=M2 3=M1)
module decode_sequencer #(
  parameter int CNT_W = 24,
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 24'd4000000
) (
  input  logic        Clock,
  input  logic        resetn,
  input  logic        go,
  input  logic        uart_done,
  input  logic        m2_done,
  input  logic        m1_done,
  input  logic [17:0] uart_addr,
  input  logic [15:0] uart_wdata,
  input  logic        uart_we_n,
  input  logic [17:0] m2_addr,
  input  logic [15:0] m2_wdata,
  input  logic        m2_we_n,
  input  logic [17:0] m1_addr,
  input  logic [15:0] m1_wdata,
  input  logic        m1_we_n,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        uart_en,
  output logic        m2start,
  output logic        m1start,
  output logic [1:0]  owner,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_phase
);
  typedef enum logic [2:0] {S_IDLE, S_UART, S_M2_START, S_M2_RUN, S_M1_START, S_M1_RUN, S_DONE, S_ERR} state_t;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_wd;
  logic [1:0] r_owner, r_err_phase;
  logic r_uart_en, r_m2start, r_m1start, r_busy, r_done, r_error;
  logic w_to, w_run;
  assign w_to = r_wd == TIMEOUT_CYCLES - CNT_W'(1);
  assign w_run = r_state inside {S_UART, S_M2_RUN, S_M1_RUN};
  // Completion is checked before the timeout, so done wins a same-cycle tie.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     w_next = go ? S_UART : S_IDLE;
      S_UART:     w_next = uart_done ? S_M2_START : w_to ? S_ERR : S_UART;
      S_M2_START: w_next = S_M2_RUN;
      S_M2_RUN:   w_next = m2_done ? S_M1_START : w_to ? S_ERR : S_M2_RUN;
      S_M1_START: w_next = S_M1_RUN;
      S_M1_RUN:   w_next = m1_done ? S_DONE : w_to ? S_ERR : S_M1_RUN;
      S_DONE:     w_next = go ? S_UART : S_DONE;
      S_ERR:      w_next = go ? S_IDLE : S_ERR;
      default:    w_next = S_IDLE;
    endcase
  end
  // Outputs are decoded from the next state so they are registered alongside it.
  always_ff @(posedge Clock or negedge resetn)
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_owner     <= 2'd0;
      r_uart_en   <= 1'b0;
      r_m2start   <= 1'b0;
      r_m1start   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_phase <= 2'd0;
      r_wd        <= '0;
    end else begin
      r_state     <= w_next;
      r_owner     <= w_next == S_UART ? 2'd1 : w_next == S_M2_RUN ? 2'd2 : w_next == S_M1_RUN ? 2'd3 : 2'd0;
      r_uart_en   <= w_next == S_UART;
      r_m2start   <= w_next == S_M2_START;
      r_m1start   <= w_next == S_M1_START;
      r_busy      <= !(w_next inside {S_IDLE, S_DONE, S_ERR});
      r_done      <= w_next == S_DONE;
      r_error     <= w_next == S_ERR;
      r_err_phase <= w_next != S_ERR ? 2'd0 : r_error ? r_err_phase : r_owner;
      r_wd        <= w_next != r_state ? '0 : (w_run && r_wd != '1) ? r_wd + CNT_W'(1) : r_wd;
    end
  always_comb begin
    SRAM_address    = r_owner == 2'd1 ? uart_addr  : r_owner == 2'd2 ? m2_addr  : r_owner == 2'd3 ? m1_addr  : 18'd0;
    SRAM_write_data = r_owner == 2'd1 ? uart_wdata : r_owner == 2'd2 ? m2_wdata : r_owner == 2'd3 ? m1_wdata : 16'd0;
    SRAM_we_n       = r_owner == 2'd1 ? uart_we_n  : r_owner == 2'd2 ? m2_we_n  : r_owner == 2'd3 ? m1_we_n  : 1'b1;
  end
  assign owner     = r_owner;
  assign uart_en   = r_uart_en;
  assign m2start   = r_m2start;
  assign m1start   = r_m1start;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign err_phase = r_err_phase;
endmodule
